mac_neuron: RTL and testbench
=============================

MAC_NEURON -- requirements
Module: mac_neuron

Interface
REQ-001 Parameter N_TAPS, default 4, number of products accumulated per result (range 1..255).
REQ-002 Parameter DATA_W, default 8, width of signed x/w operands (fixed at 8 for this revision).
REQ-003 clk  input  1  single rising-edge clock.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 start  input  1  begin a new accumulation; sampled only in IDLE.
REQ-006 bias_in  input  18  signed bias, loaded into the accumulator on accepted start.
REQ-007 in_valid  input  1  x_in/w_in carry a valid operand pair.
REQ-008 x_in  input  8  signed activation operand.
REQ-009 w_in  input  8  signed weight operand.
REQ-010 in_ready  output  1  block accepts an operand pair this cycle.
REQ-011 dout_msb  output  6  bits [17:12] of the registered 18-bit signed result.
REQ-012 dout_lsb  output  12  bits [11:0] of the registered result.
REQ-013 dout_valid  output  1  one-cycle pulse: dout_msb/dout_lsb hold a new result.
REQ-014 sat  output  1  result of the last computation was clamped.
REQ-015 busy  output  1  state is not IDLE.

Function
REQ-016 FSM states are IDLE, ACCUM and DONE.
REQ-017 IDLE with start=1: acc <= bias_in, beat count <= 0, sat_int <= 0, next state ACCUM.
REQ-018 IDLE with start=0: no state change; in_valid is ignored.
REQ-019 in_ready is combinationally 1 only in ACCUM.
REQ-020 A beat is accepted on a rising edge where in_valid=1 and in_ready=1; no other cycle alters acc.
REQ-021 Product = x_in*w_in as 16-bit signed, sign-extended to 18 bits.
REQ-022 Accumulation uses a 19-bit sum clamped to [-131072, +131071]; any clamp sets sat_int sticky for the current computation.
REQ-023 On the N_TAPS-th accepted beat: dout_msb/dout_lsb <= clamped final sum, sat <= sat_int OR the clamp of that beat, next state DONE.
REQ-024 DONE lasts exactly one cycle with dout_valid=1, then IDLE.
REQ-025 Latency: dout_valid is high in the cycle immediately following the edge that accepted the last beat.
REQ-026 start is ignored in ACCUM and DONE; a start in the IDLE cycle directly after DONE is accepted.
REQ-027 dout_msb, dout_lsb and sat hold their values until the next REQ-023 update.
REQ-028 in_valid gaps in ACCUM stall the computation indefinitely without timeout.
REQ-029 N_TAPS=1: one accepted beat moves ACCUM to DONE.

Reset
REQ-030 rst=1 forces, asynchronously: state IDLE, acc 0, count 0, dout_msb 0, dout_lsb 0, dout_valid 0, sat 0; in_ready 0 and busy 0 follow from IDLE.
REQ-031 rst asserted mid-ACCUM discards the partial sum; no dout_valid is issued for it.
REQ-032 After rst deasserts, the first start is honoured on the first rising edge.

Structure
REQ-033 Shared package mac_pkg holds ACC_W=18, MSB_W=6, LSB_W=12, SAT_MAX, SAT_MIN and the FSM state type.
REQ-034 One combinational sub-module sat_add18 (18-bit + 18-bit signed saturating adder with overflow flag) is instantiated once.
REQ-035 dout_msb/dout_lsb connect directly to the downstream ReLU stage's dout_msb/dout_lsb inputs.

Verification
REQ-036 bias=0, pairs (3,4),(−2,5),(10,10),(1,−1) -> dout_valid one cycle after the 4th beat, result 12−10+100−1=101 (msb=0x00, lsb=0x065), sat=0.
REQ-037 bias=131000, pairs (127,127)x4 -> result clamped to 131071 (msb=0x1F, lsb=0xFFF), sat=1.
REQ-038 bias=−131072, pairs (−128,127)x4 -> result −131072 (msb=0x20, lsb=0x000), sat=1.
REQ-039 in_valid deasserted for 3 cycles between beats 2 and 3, start pulsed during ACCUM -> identical result to REQ-036, start ignored, busy high throughout.
REQ-040 rst pulsed after beat 2, then new run bias=5 with (1,1)x4 -> no dout_valid for the aborted run, second result 9, sat=0.
REQ-041 Back-to-back: start asserted in the IDLE cycle after DONE -> second run accepted; prior result held until the second dout_valid.

Source files
------------

// File: rtl/mac_pkg.sv
// Shared widths, saturation limits and FSM state type for the MAC neuron.
package mac_pkg;

    localparam int ACC_W  = 18;
    localparam int MSB_W  = 6;
    localparam int LSB_W  = 12;
    localparam int PROD_W = 16;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 18'sd131071;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -18'sd131072;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic signed [ACC_W-1:0] sext_prod(input logic signed [PROD_W-1:0] p);
        return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

endpackage

// File: rtl/sat_add18.sv
// Combinational 18-bit signed adder that clamps to the 18-bit range and flags the clamp.
module sat_add18
    import mac_pkg::*;
(
    input  logic signed [ACC_W-1:0] a_in,
    input  logic signed [ACC_W-1:0] b_in,
    output logic signed [ACC_W-1:0] sum_out,
    output logic                    ovf_out
);

    logic [ACC_W:0] wide;

    always_comb begin
        wide    = {a_in[ACC_W-1], a_in} + {b_in[ACC_W-1], b_in};
        ovf_out = wide[ACC_W] ^ wide[ACC_W-1];
        sum_out = wide[ACC_W-1:0];
        if (ovf_out) begin
            // The extra top bit is the true sign of the unclamped sum.
            sum_out = wide[ACC_W] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/mac_neuron.sv
// Multiply-accumulate neuron: bias plus N_TAPS signed products, saturated to 18 bits,
// presented as a split msb/lsb result with a one-cycle valid pulse.
module mac_neuron
    import mac_pkg::*;
#(
    parameter int N_TAPS = 4,
    parameter int DATA_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic signed [ACC_W-1:0]  bias_in,
    input  logic                     in_valid,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic signed [DATA_W-1:0] w_in,
    output logic                     in_ready,
    output logic [MSB_W-1:0]         dout_msb,
    output logic [LSB_W-1:0]         dout_lsb,
    output logic                     dout_valid,
    output logic                     sat,
    output logic                     busy
);

    localparam int CNT_W = 8;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_TAPS - 1);

    state_t                  state_q, state_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    sat_int_q, sat_int_d;
    logic signed [ACC_W-1:0] res_q, res_d;
    logic                    sat_q, sat_d;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  sum;
    logic                     ovf;
    logic                     beat;

    assign prod     = x_in * w_in;
    assign prod_ext = sext_prod(prod);

    sat_add18 u_sat_add18 (
        .a_in    (acc_q),
        .b_in    (prod_ext),
        .sum_out (sum),
        .ovf_out (ovf)
    );

    assign in_ready   = (state_q == ST_ACCUM);
    assign busy       = (state_q != ST_IDLE);
    assign dout_valid = (state_q == ST_DONE);
    assign beat       = in_valid & in_ready;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        sat_int_d = sat_int_q;
        res_d     = res_q;
        sat_d     = sat_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d     = bias_in;
                    cnt_d     = '0;
                    sat_int_d = 1'b0;
                    state_d   = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (beat) begin
                    acc_d     = sum;
                    sat_int_d = sat_int_q | ovf;
                    if (cnt_q == LAST_BEAT) begin
                        // Final beat publishes directly from the adder so the result
                        // is visible in the cycle right after acceptance.
                        res_d   = sum;
                        sat_d   = sat_int_q | ovf;
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            sat_int_q <= 1'b0;
            res_q     <= '0;
            sat_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            sat_int_q <= sat_int_d;
            res_q     <= res_d;
            sat_q     <= sat_d;
        end
    end

    assign dout_msb = res_q[ACC_W-1:LSB_W];
    assign dout_lsb = res_q[LSB_W-1:0];
    assign sat      = sat_q;

endmodule

// File: tb/tb_mac_neuron.sv
// Scoreboard bench for mac_neuron: directed and randomized jobs against an integer reference model.
module tb_mac_neuron;

    localparam int N = 4;
    typedef int vec_t[N];
    typedef struct packed {
        logic [5:0]  msb;
        logic [11:0] lsb;
        logic        sat;
    } res_t;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic signed [17:0] bias_in;
    logic               in_valid;
    logic signed [7:0]  x_in;
    logic signed [7:0]  w_in;
    logic               in_ready;
    logic [5:0]         dout_msb;
    logic [11:0]        dout_lsb;
    logic               dout_valid;
    logic               sat;
    logic               busy;

    always #5 clk = ~clk;

    mac_neuron #(.N_TAPS(N), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .bias_in    (bias_in),
        .in_valid   (in_valid),
        .x_in       (x_in),
        .w_in       (w_in),
        .in_ready   (in_ready),
        .dout_msb   (dout_msb),
        .dout_lsb   (dout_lsb),
        .dout_valid (dout_valid),
        .sat        (sat),
        .busy       (busy)
    );

    int   checks = 0;
    int   errors = 0;
    res_t exp_q[$];
    res_t held;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic with clamping after every product.
    function automatic res_t model(input int bias, input vec_t xs, input vec_t ws);
        int          acc;
        bit          s;
        logic [17:0] r;
        res_t        o;
        acc = bias;
        s   = 1'b0;
        for (int i = 0; i < N; i++) begin
            acc = acc + xs[i] * ws[i];
            if (acc > 131071) begin
                acc = 131071;
                s   = 1'b1;
            end else if (acc < -131072) begin
                acc = -131072;
                s   = 1'b1;
            end
        end
        r     = 18'(acc);
        o.msb = r[17:12];
        o.lsb = r[11:0];
        o.sat = s;
        return o;
    endfunction

    always @(negedge clk) begin
        if (rst === 1'b0 && dout_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_dout_valid: got msb=0x%0h lsb=0x%0h with no result pending",
                         dout_msb, dout_lsb);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                check("result", {13'd0, dout_msb, dout_lsb, sat}, {13'd0, e});
            end
        end
    end

    task automatic run_job(input int bias, input vec_t xs, input vec_t ws, input vec_t gaps,
                           input bit poke_start);
        int   waitc;
        res_t e;
        waitc = 0;
        while (busy !== 1'b0 && waitc < 50) begin
            @(posedge clk); #1;
            waitc++;
        end
        check("idle_before_start", {31'd0, busy}, 32'd0);
        start   = 1'b1;
        bias_in = 18'(bias);
        @(posedge clk); #1;
        start   = 1'b0;
        bias_in = 18'($urandom);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        check("in_ready_accum", {31'd0, in_ready}, 32'd1);
        check("held_result", {13'd0, dout_msb, dout_lsb, sat}, {13'd0, held});
        for (int i = 0; i < N; i++) begin
            for (int g = 0; g < gaps[i]; g++) begin
                in_valid = 1'b0;
                x_in     = 8'($urandom);
                w_in     = 8'($urandom);
                start    = poke_start;
                @(posedge clk); #1;
                start = 1'b0;
                check("busy_in_gap", {31'd0, busy}, 32'd1);
            end
            in_valid = 1'b1;
            x_in     = 8'(xs[i]);
            w_in     = 8'(ws[i]);
            if (i == N - 1) begin
                e = model(bias, xs, ws);
                exp_q.push_back(e);
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (i < N - 1) check("busy_mid_run", {31'd0, busy}, 32'd1);
        end
        check("latency_dout_valid", {31'd0, dout_valid}, 32'd1);
        held = e;
        @(posedge clk); #1;
        check("done_one_cycle", {31'd0, dout_valid}, 32'd0);
        check("idle_after_done", {30'd0, busy, in_ready}, 32'd0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'($urandom);
            x_in     = 8'($urandom);
            w_in     = 8'($urandom);
            @(posedge clk); #1;
            check("idle_stays_idle", {31'd0, busy}, 32'd0);
        end
        in_valid = 1'b0;
    endtask

    function automatic int rand_s8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    vec_t xs, ws, gaps, nogap;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; bias_in = '0; in_valid = 1'b0; x_in = '0; w_in = '0;
        held  = '0;
        nogap = '{0, 0, 0, 0};
        #1;
        check("reset_outputs", {13'd0, dout_msb, dout_lsb, sat}, 32'd0);
        check("reset_ctrl", {29'd0, dout_valid, busy, in_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic sum 12-10+100-1 = 101
        xs = '{3, -2, 10, 1}; ws = '{4, 5, 10, -1};
        run_job(0, xs, ws, nogap, 1'b0);
        // Positive clamp
        xs = '{127, 127, 127, 127}; ws = '{127, 127, 127, 127};
        run_job(131000, xs, ws, nogap, 1'b0);
        // Negative clamp
        xs = '{-128, -128, -128, -128}; ws = '{127, 127, 127, 127};
        run_job(-131072, xs, ws, nogap, 1'b0);
        // Stall of 3 cycles before beat 3 with start pokes ignored
        xs = '{3, -2, 10, 1}; ws = '{4, 5, 10, -1};
        gaps = '{0, 0, 3, 0};
        run_job(0, xs, ws, gaps, 1'b1);

        // Abort mid-run with asynchronous reset
        idle_cycles(2);
        start = 1'b1; bias_in = 18'sd777;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; x_in = 8'sd50; w_in = 8'sd50;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_reset_outputs", {13'd0, dout_msb, dout_lsb, sat}, 32'd0);
        check("async_reset_ctrl", {29'd0, dout_valid, busy, in_ready}, 32'd0);
        #1 rst = 1'b0;
        held = '0;
        xs = '{1, 1, 1, 1}; ws = '{1, 1, 1, 1};
        run_job(5, xs, ws, nogap, 1'b0);
        // Back-to-back: run_job returns in the IDLE cycle right after DONE
        xs = '{-7, 9, 100, -128}; ws = '{3, -4, 2, -128};
        run_job(-3, xs, ws, nogap, 1'b0);

        for (int r = 0; r < 24; r++) begin
            int bias;
            case ($urandom_range(0, 3))
                0: bias = 131071 - int'($urandom_range(0, 40000));
                1: bias = -131072 + int'($urandom_range(0, 40000));
                default: bias = int'($urandom_range(0, 262143)) - 131072;
            endcase
            for (int i = 0; i < N; i++) begin
                xs[i]   = rand_s8();
                ws[i]   = rand_s8();
                gaps[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
            end
            run_job(bias, xs, ws, gaps, 1'($urandom));
            if ($urandom_range(0, 1) == 1) idle_cycles(int'($urandom_range(1, 4)));
        end

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
